// File: rtl/mux_8_1_rr_sched_if.sv
// rtl/mux_8_1_rr_sched_if.sv - request/data/stall inputs and grant/sample outputs of the shared 8:1 mux
interface mux_8_1_rr_sched_if;
  logic [7:0] d;
  logic [7:0] req;
  logic       stall;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       out;
  logic [2:0] out_src;
  logic       out_valid;

  modport master (
    output d, req, stall,
    input  grant, sel, out, out_src, out_valid
  );

  modport slave (
    input  d, req, stall,
    output grant, sel, out, out_src, out_valid
  );
endinterface

// File: rtl/mux_8_1_rr_sched.sv
// rtl/mux_8_1_rr_sched.sv - round-robin scheduler sharing one 8:1 bit mux, with bounded hold and registered tagged sample
module mux_8_1_rr_sched #(
  parameter int MAX_HOLD = 4,
  parameter int PTR_INIT = 0
) (
  input logic               clk,
  input logic               rst,
  mux_8_1_rr_sched_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);
  localparam logic [2:0] PTR_RST  = 3'(PTR_INIT);

  state_t     state, nxt_state;
  logic [2:0] sel_r, nxt_sel;
  logic [3:0] hold_cnt, nxt_hold;
  logic [2:0] ptr, nxt_ptr;
  logic       out_r;
  logic [2:0] out_src_r;
  logic       out_valid_r;

  logic [7:0] held;
  logic [3:0] pick_idle;
  logic [3:0] pick_rel;
  logic       release_now;

  // Returns {found, index} of the first set bit scanning circularly from p.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0;
    for (int i = 0; i < 8; i++) begin
      idx = p + 3'(i);
      if (!res[3] && r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign held = 8'b1 << sel_r;

  always_comb begin
    nxt_state   = state;
    nxt_sel     = sel_r;
    nxt_hold    = hold_cnt;
    nxt_ptr     = ptr;
    release_now = 1'b0;
    pick_idle   = rr_pick(bus.req, ptr);
    // Starting one past the holder puts the holder last in line.
    pick_rel    = rr_pick(bus.req, sel_r + 3'd1);
    case (state)
      IDLE: begin
        if (pick_idle[3]) begin
          nxt_state = GRANT;
          nxt_sel   = pick_idle[2:0];
          nxt_hold  = 4'd1;
        end
      end
      GRANT: begin
        if (!bus.stall) begin
          release_now = !bus.req[sel_r] ||
                        (hold_cnt == HOLD_MAX && (bus.req & ~held) != 8'b0);
          if (release_now) begin
            nxt_ptr = sel_r + 3'd1;
            if (pick_rel[3]) begin
              nxt_sel  = pick_rel[2:0];
              nxt_hold = 4'd1;
            end else begin
              nxt_state = IDLE;
              nxt_sel   = 3'd0;
              nxt_hold  = 4'd0;
            end
          end else if (hold_cnt != HOLD_MAX) begin
            nxt_hold = hold_cnt + 4'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sel_r       <= 3'd0;
      hold_cnt    <= 4'd0;
      ptr         <= PTR_RST;
      out_r       <= 1'b0;
      out_src_r   <= 3'd0;
      out_valid_r <= 1'b0;
    end else begin
      state    <= nxt_state;
      sel_r    <= nxt_sel;
      hold_cnt <= nxt_hold;
      ptr      <= nxt_ptr;
      if (!bus.stall) begin
        out_r       <= bus.d[sel_r];
        out_src_r   <= sel_r;
        out_valid_r <= (state == GRANT);
      end
    end
  end

  assign bus.grant     = (state == GRANT) ? held : 8'b0;
  assign bus.sel       = sel_r;
  assign bus.out       = out_r;
  assign bus.out_src   = out_src_r;
  assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_mux_8_1_rr_sched.sv
// tb/tb_mux_8_1_rr_sched.sv - directed vector table plus rotation, saturation and stall sequences
module tb_mux_8_1_rr_sched;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mux_8_1_rr_sched_if bus();

  mux_8_1_rr_sched #(.MAX_HOLD(4), .PTR_INIT(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       stall;
    logic [7:0] req;
    logic [7:0] d;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       out;
    logic [2:0] src;
    logic       valid;
  } vec_t;

  vec_t tbl[14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = 8'h00;
    bus.stall = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    int idx;
    int pidx;

    clk = 1'b0;
    rst = 1'b1;
    bus.d = 8'h00;
    bus.req = 8'h00;
    bus.stall = 1'b0;
    total = 0;
    bad = 0;

    //                rst stall req    d      grant  sel   out   src   valid
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 3'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 8'h01, 8'h01, 8'h01, 3'd0, 1'b1, 3'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 8'h01, 8'h01, 8'h01, 3'd0, 1'b1, 3'd0, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 8'h01, 8'h00, 3'd0, 1'b1, 3'd0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 8'h01, 8'h00, 3'd0, 1'b1, 3'd0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 8'h80, 8'h80, 8'h80, 3'd7, 1'b0, 3'd0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 8'h81, 8'h80, 8'h80, 3'd7, 1'b1, 3'd7, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 8'h01, 8'h80, 8'h01, 3'd0, 1'b1, 3'd7, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 8'h01, 8'h80, 8'h01, 3'd0, 1'b0, 3'd0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 3'd0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 8'h04, 8'h04, 8'h04, 3'd2, 1'b0, 3'd0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 8'h04, 8'h04, 8'h04, 3'd2, 1'b0, 3'd0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 8'h04, 8'h04, 8'h00, 3'd0, 1'b0, 3'd0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 8'h04, 8'h00, 3'd0, 1'b0, 3'd0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      rst       = tbl[i].rst;
      bus.stall = tbl[i].stall;
      bus.req   = tbl[i].req;
      bus.d     = tbl[i].d;
      step();
      chk($sformatf("v%0d grant", i), bus.grant, tbl[i].grant);
      chk($sformatf("v%0d sel", i), 8'(bus.sel), 8'(tbl[i].sel));
      chk($sformatf("v%0d out", i), 8'(bus.out), 8'(tbl[i].out));
      chk($sformatf("v%0d out_src", i), 8'(bus.out_src), 8'(tbl[i].src));
      chk($sformatf("v%0d out_valid", i), 8'(bus.out_valid), 8'(tbl[i].valid));
    end

    // all requesting: each index held 4 cycles, back to back
    do_reset();
    pat = 8'hA5;
    bus.d = pat;
    bus.req = 8'hFF;
    for (int n = 1; n <= 40; n++) begin
      step();
      idx = ((n - 1) / 4) % 8;
      chk($sformatf("rot%0d grant", n), bus.grant, 8'b1 << idx);
      chk($sformatf("rot%0d sel", n), 8'(bus.sel), 8'(idx));
      if (n >= 2) begin
        pidx = ((n - 2) / 4) % 8;
        chk($sformatf("rot%0d out_src", n), 8'(bus.out_src), 8'(pidx));
        chk($sformatf("rot%0d out", n), 8'(bus.out), 8'(pat[pidx]));
        chk($sformatf("rot%0d out_valid", n), 8'(bus.out_valid), 8'h01);
      end
    end

    // sole requester keeps the grant; saturated hold releases at once when another shows up
    do_reset();
    bus.req = 8'h20;
    for (int n = 1; n <= 20; n++) begin
      step();
      chk($sformatf("sole%0d grant", n), bus.grant, 8'h20);
    end
    bus.req = 8'h21;
    step();
    chk("sole_release grant", bus.grant, 8'h01);

    // stall freezes hold progress and the output register
    do_reset();
    bus.req = 8'h88;
    bus.d = 8'h08;
    step();
    chk("st1 grant", bus.grant, 8'h08);
    step();
    chk("st2 grant", bus.grant, 8'h08);
    chk("st2 out", 8'(bus.out), 8'h01);
    chk("st2 out_valid", 8'(bus.out_valid), 8'h01);
    bus.stall = 1'b1;
    bus.d = 8'h00;
    for (int n = 1; n <= 5; n++) begin
      step();
      chk($sformatf("stall%0d grant", n), bus.grant, 8'h08);
      chk($sformatf("stall%0d out", n), 8'(bus.out), 8'h01);
      chk($sformatf("stall%0d out_src", n), 8'(bus.out_src), 8'h03);
      chk($sformatf("stall%0d out_valid", n), 8'(bus.out_valid), 8'h01);
    end
    bus.stall = 1'b0;
    bus.d = 8'h08;
    step();
    chk("unst1 grant", bus.grant, 8'h08);
    step();
    chk("unst2 grant", bus.grant, 8'h08);
    step();
    chk("unst3 grant", bus.grant, 8'h80);
    chk("unst3 sel", 8'(bus.sel), 8'h07);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_8_1_rr_sched.md
Name: mux_8_1_rr_sched

Overview:
- Round-robin scheduler that shares one 8:1 bit-mux datapath between 8 requesters.
- Arbitrates req[7:0] and drives the mux select (sel) plus a one-hot grant.
- Registers the selected data bit, tagged with its source index, toward a downstream consumer.
- Supports a downstream stall and a bounded per-grant hold time so no requester can starve the others.

Parameters:
- MAX_HOLD, 4, max consecutive non-stalled cycles one requester keeps the grant while others wait; legal range 1..15.
- PTR_INIT, 0, round-robin pointer value after reset; legal range 0..7.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- D  input  8  data bits D[0]..D[7]; D[i] belongs to requester i.
- req  input  8  request vector; req[i]=1 means requester i wants the datapath.
- stall  input  1  downstream not ready; freezes scheduler and output.
- grant  output  8  one-hot grant, or all-zero when idle.
- sel  output  3  mux select = index of the granted requester; 0 when idle.
- out  output  1  registered D[sel] sample.
- out_src  output  3  index of the requester that produced out.
- out_valid  output  1  out/out_src hold a valid sample.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst is synchronous, active-high, and has priority over stall.
- Reset values:
  - State=IDLE, grant=0, sel=0, out=0, out_src=0, out_valid=0.
  - ptr=PTR_INIT, hold_cnt=0.
- FSM states: IDLE and GRANT.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the winner at the next edge: the first set req bit scanning ptr, ptr+1, ... ,7, 0, ... (circular, wraps 7->0).
  - On that edge: grant=onehot(winner), sel=winner, hold_cnt=1, state -> GRANT.
  - The IDLE-to-GRANT transition happens even if stall=1. Stall only freezes GRANT-state progress and the output register.
- GRANT with stall=1:
  - grant, sel, hold_cnt, ptr, out, out_src and out_valid all hold.
  - Requests are ignored until stall drops.
- GRANT with stall=0, release conditions:
  - (a) req[sel]==0, or
  - (b) hold_cnt==MAX_HOLD and any other req bit is set.
- On release:
  - ptr <= (sel+1) mod 8.
  - Re-arbitrate in the same edge from the new ptr over the current req. The releasing requester is included but has lowest priority.
  - If a winner exists, grant switches directly with no idle gap cycle, and hold_cnt=1.
  - If no winner exists, state -> IDLE, grant=0, sel=0.
- No release:
  - Grant is kept.
  - hold_cnt increments, saturating at MAX_HOLD. Saturation matters when the holder is the sole requester: it keeps the grant indefinitely.
- Output register:
  - On each edge with stall=0: out <= D[sel], out_src <= sel, out_valid <= (grant!=0). These use the pre-edge grant/sel values.
  - Latency is one cycle: the sample taken while requester i is granted appears on out exactly one cycle later.
  - When grant returns to 0, out_valid falls one cycle later; out and out_src hold their last values.
- Invariants:
  - At most one grant bit is ever set.
  - sel always equals the index of the set grant bit.
  - grant is never set for a requester whose req was 0 at arbitration.
- Timing: sel/grant are registered, so the mux path is combinational only from D.

Test Plan:
- Reset, then req=8'h01, D=8'h01 -> next edge grant=8'h01, sel=0. One cycle later out=1, out_src=0, out_valid=1.
- req=8'hFF held, MAX_HOLD=4, stall=0:
  - Grant rotates 0,1,2,...,7,0, each held exactly 4 cycles, with no idle cycles between grants.
  - out_src follows the same sequence, lagging by one cycle.
- Sole requester with req=8'h20 for 20 cycles -> grant stays 8'h20 throughout; hold_cnt saturates at 4; no release.
- Requester 3 granted with hold_cnt=2, then stall=1 for 5 cycles while req=8'h88:
  - grant, out and out_valid frozen.
  - After stall drops: 2 more cycles on requester 3, then grant moves to requester 7.
- Wrap-around: grant on 7, req=8'h81, 7 releases -> ptr=0, grant=8'h01.
- Reset mid-operation and all-drop:
  - With grant=8'h04 and stall=1, assert rst for 1 cycle -> all outputs reach reset values at the next edge.
  - Drop req to 0 while granted -> grant=0 next edge; out_valid=0 one cycle after that.
